// File: rtl/puf_batch_controller_pkg.sv
// rtl/puf_batch_controller_pkg.sv - shared states, register map and status packing for the PUF batch controller
package puf_batch_controller_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_PARAM_REQ,
    S_PARAM_WAIT,
    S_RD_REQ,
    S_RD_WAIT,
    S_EVAL,
    S_WR,
    S_STATUS,
    S_DONE
  } ctrlState_t;

  typedef enum logic [1:0] {
    T_IDLE,
    T_TRIG,
    T_WAIT
  } timerState_t;

  localparam logic [7:0] REG_OPA    = 8'd0;
  localparam logic [7:0] REG_OPB    = 8'd1;
  localparam logic [7:0] REG_COUNT  = 8'd2;
  localparam logic [7:0] REG_STATUS = 8'd3;

  localparam int STATUS_COMPLETED_LSB = 0;
  localparam int STATUS_TIMEOUTS_LSB  = 16;

  function automatic logic [31:0] packStatus(input logic [15:0] timeouts, input logic [15:0] completed);
    logic [31:0] word;
    word = '0;
    word[STATUS_TIMEOUTS_LSB +: 16]  = timeouts;
    word[STATUS_COMPLETED_LSB +: 16] = completed;
    return word;
  endfunction

  function automatic logic [15:0] clampBatch(input logic [15:0] requested, input logic [15:0] limit);
    return (requested > limit) ? limit : requested;
  endfunction

endpackage

// File: rtl/puf_batch_controller_eval_timer.sv
// rtl/puf_batch_controller_eval_timer.sv - PUF trigger pulse, bounded wait for pufDone, latched response
module puf_eval_timer
  import puf_batch_controller_pkg::*;
#(
  parameter int RESP_BYTES     = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    evalStart,
  input  logic                    pufDone,
  input  logic [8*RESP_BYTES-1:0] pufResponse,
  output logic                    pufTrigger,
  output logic                    evalDone,
  output logic                    evalTimedOut,
  output logic [8*RESP_BYTES-1:0] evalResponse
);

  localparam logic [31:0] LAST_WAIT = 32'(TIMEOUT_CYCLES - 1);

  timerState_t state, stateNext;
  logic [31:0] waitCount;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= T_IDLE;
      waitCount    <= '0;
      evalDone     <= 1'b0;
      evalTimedOut <= 1'b0;
      evalResponse <= '0;
    end else begin
      state    <= stateNext;
      evalDone <= 1'b0;
      case (state)
        T_TRIG: waitCount <= '0;
        T_WAIT: begin
          // a strobe in the final allowed cycle still wins over the timeout
          if (pufDone) begin
            evalDone     <= 1'b1;
            evalTimedOut <= 1'b0;
            evalResponse <= pufResponse;
          end else if (waitCount == LAST_WAIT) begin
            evalDone     <= 1'b1;
            evalTimedOut <= 1'b1;
            evalResponse <= '1;
          end else begin
            waitCount <= waitCount + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      T_IDLE:  if (evalStart) stateNext = T_TRIG;
      T_TRIG:  stateNext = T_WAIT;
      T_WAIT:  if (pufDone || (waitCount == LAST_WAIT)) stateNext = T_IDLE;
      default: stateNext = T_IDLE;
    endcase
  end

  assign pufTrigger = (state == T_TRIG);

endmodule

// File: rtl/puf_batch_controller.sv
// rtl/puf_batch_controller.sv - runs a batch of PUF evaluations from memory and reports status
module puf_batch_controller
  import puf_batch_controller_pkg::*;
#(
  parameter int INMEM_ADDRESS_WIDTH  = 17,
  parameter int OUTMEM_ADDRESS_WIDTH = 13,
  parameter int CHAL_BYTES           = 16,
  parameter int RESP_BYTES           = 2,
  parameter int TIMEOUT_CYCLES       = 65535
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            userRunValue,
  output logic                            userRunClear,
  output logic                            register32CmdReq,
  input  logic                            register32CmdAck,
  output logic [31:0]                     register32WriteData,
  output logic [7:0]                      register32Address,
  output logic                            register32WriteEn,
  input  logic                            register32ReadDataValid,
  input  logic [31:0]                     register32ReadData,
  output logic                            inputMemoryReadReq,
  input  logic                            inputMemoryReadAck,
  output logic [INMEM_ADDRESS_WIDTH-1:0]  inputMemoryReadAdd,
  input  logic                            inputMemoryReadDataValid,
  input  logic [7:0]                      inputMemoryReadData,
  output logic                            outputMemoryWriteReq,
  input  logic                            outputMemoryWriteAck,
  output logic [OUTMEM_ADDRESS_WIDTH-1:0] outputMemoryWriteAdd,
  output logic [7:0]                      outputMemoryWriteData,
  output logic                            outputMemoryWriteByteMask,
  output logic                            pufTrigger,
  output logic [8*CHAL_BYTES-1:0]         pufChallenge,
  output logic [15:0]                     pufOpA,
  output logic [15:0]                     pufOpB,
  input  logic                            pufDone,
  input  logic [8*RESP_BYTES-1:0]         pufResponse,
  output logic [7:0]                      LED
);

  // batch size limited so neither memory's address space is overrun
  localparam int unsigned MAX_BY_OUT = (32'd1 << OUTMEM_ADDRESS_WIDTH) / RESP_BYTES;
  localparam int unsigned MAX_BY_IN  = (32'd1 << INMEM_ADDRESS_WIDTH) / CHAL_BYTES;
  localparam int unsigned MAX_RAW    = (MAX_BY_OUT < MAX_BY_IN) ? MAX_BY_OUT : MAX_BY_IN;
  localparam logic [15:0] MAX_BATCH  = (MAX_RAW > 32'hFFFF) ? 16'hFFFF : MAX_RAW[15:0];

  ctrlState_t state, stateNext;

  logic [7:0]                paramAddr;
  logic [15:0]               batchCount, challengeIdx, byteIdx, respIdx, completed, timeouts;
  logic [8*RESP_BYTES-1:0]   respShift;
  logic                      ledBusy, ledDone, ledTimeout;
  logic                      timerStart, evalDone, evalTimedOut;
  logic [8*RESP_BYTES-1:0]   evalResponse;
  logic [15:0]               clampedCount;
  logic                      lastByte, lastResp, lastChallenge;
  logic                      unusedReadBits;

  assign clampedCount   = clampBatch(register32ReadData[15:0], MAX_BATCH);
  assign unusedReadBits = ^register32ReadData[31:16];
  assign lastByte       = (byteIdx == 16'(CHAL_BYTES - 1));
  assign lastResp       = (respIdx == 16'(RESP_BYTES - 1));
  assign lastChallenge  = (challengeIdx == batchCount - 16'd1);

  puf_eval_timer #(
    .RESP_BYTES    (RESP_BYTES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk         (clk),
    .reset       (reset),
    .evalStart   (timerStart),
    .pufDone     (pufDone),
    .pufResponse (pufResponse),
    .pufTrigger  (pufTrigger),
    .evalDone    (evalDone),
    .evalTimedOut(evalTimedOut),
    .evalResponse(evalResponse)
  );

  always_comb begin
    stateNext  = state;
    timerStart = 1'b0;
    case (state)
      S_IDLE:       if (userRunValue && !userRunClear) stateNext = S_PARAM_REQ;
      S_PARAM_REQ:  if (register32CmdAck) stateNext = S_PARAM_WAIT;
      S_PARAM_WAIT: begin
        if (register32ReadDataValid) begin
          if (paramAddr == REG_COUNT)
            stateNext = (clampedCount == 16'd0) ? S_STATUS : S_RD_REQ;
          else
            stateNext = S_PARAM_REQ;
        end
      end
      S_RD_REQ:     if (inputMemoryReadAck) stateNext = S_RD_WAIT;
      S_RD_WAIT: begin
        if (inputMemoryReadDataValid) begin
          if (lastByte) begin
            stateNext  = S_EVAL;
            timerStart = 1'b1;
          end else begin
            stateNext = S_RD_REQ;
          end
        end
      end
      S_EVAL:       if (evalDone) stateNext = S_WR;
      S_WR: begin
        if (outputMemoryWriteAck && lastResp)
          stateNext = lastChallenge ? S_STATUS : S_RD_REQ;
      end
      S_STATUS:     if (register32CmdAck) stateNext = S_DONE;
      S_DONE:       stateNext = S_IDLE;
      default:      stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      paramAddr    <= REG_OPA;
      batchCount   <= '0;
      challengeIdx <= '0;
      byteIdx      <= '0;
      respIdx      <= '0;
      completed    <= '0;
      timeouts     <= '0;
      respShift    <= '0;
      pufChallenge <= '0;
      pufOpA       <= '0;
      pufOpB       <= '0;
      ledBusy      <= 1'b0;
      ledDone      <= 1'b0;
      ledTimeout   <= 1'b0;
    end else begin
      state <= stateNext;
      case (state)
        S_IDLE: begin
          if (stateNext == S_PARAM_REQ) begin
            paramAddr    <= REG_OPA;
            challengeIdx <= '0;
            byteIdx      <= '0;
            respIdx      <= '0;
            completed    <= '0;
            timeouts     <= '0;
            ledBusy      <= 1'b1;
            ledDone      <= 1'b0;
            ledTimeout   <= 1'b0;
          end
        end
        S_PARAM_WAIT: begin
          if (register32ReadDataValid) begin
            case (paramAddr)
              REG_OPA: pufOpA     <= register32ReadData[15:0];
              REG_OPB: pufOpB     <= register32ReadData[15:0];
              default: batchCount <= clampedCount;
            endcase
            paramAddr <= paramAddr + 8'd1;
          end
        end
        S_RD_WAIT: begin
          if (inputMemoryReadDataValid) begin
            for (int b = 0; b < CHAL_BYTES; b++)
              if (byteIdx == 16'(b)) pufChallenge[8*b +: 8] <= inputMemoryReadData;
            byteIdx <= lastByte ? 16'd0 : byteIdx + 16'd1;
          end
        end
        S_EVAL: begin
          if (evalDone) begin
            respShift <= evalResponse;
            respIdx   <= '0;
            if (evalTimedOut) begin
              timeouts   <= timeouts + 16'd1;
              ledTimeout <= 1'b1;
            end
          end
        end
        S_WR: begin
          // response goes out MSB first by shifting the next byte up to the top
          if (outputMemoryWriteAck) begin
            respShift <= respShift << 8;
            if (lastResp) begin
              respIdx      <= '0;
              completed    <= completed + 16'd1;
              challengeIdx <= challengeIdx + 16'd1;
            end else begin
              respIdx <= respIdx + 16'd1;
            end
          end
        end
        S_DONE: begin
          ledBusy <= 1'b0;
          ledDone <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign userRunClear        = (state == S_DONE);
  assign register32CmdReq    = (state == S_PARAM_REQ) || (state == S_STATUS);
  assign register32WriteEn   = (state == S_STATUS);
  assign register32Address   = (state == S_STATUS) ? REG_STATUS : paramAddr;
  assign register32WriteData = (state == S_STATUS) ? packStatus(timeouts, completed) : 32'd0;

  assign inputMemoryReadReq = (state == S_RD_REQ);
  assign inputMemoryReadAdd = INMEM_ADDRESS_WIDTH'(challengeIdx) * INMEM_ADDRESS_WIDTH'(CHAL_BYTES)
                            + INMEM_ADDRESS_WIDTH'(byteIdx);

  assign outputMemoryWriteReq      = (state == S_WR);
  assign outputMemoryWriteAdd      = OUTMEM_ADDRESS_WIDTH'(challengeIdx) * OUTMEM_ADDRESS_WIDTH'(RESP_BYTES)
                                   + OUTMEM_ADDRESS_WIDTH'(respIdx);
  assign outputMemoryWriteData     = respShift[8*RESP_BYTES-1 -: 8];
  assign outputMemoryWriteByteMask = 1'b1;

  assign LED = {5'b0, ledTimeout, ledDone, ledBusy};

endmodule

// File: tb/tb_puf_batch_controller.sv
// tb/tb_puf_batch_controller.sv - scoreboard bench for puf_batch_controller
module tb_puf_batch_controller;

  localparam int IW = 17;
  localparam int OW = 13;
  localparam int CB = 16;
  localparam int RB = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic userRunValue = 1'b0;
  logic userRunClear;
  logic register32CmdReq, register32CmdAck, register32WriteEn, register32ReadDataValid;
  logic [31:0] register32WriteData, register32ReadData;
  logic [7:0] register32Address;
  logic inputMemoryReadReq, inputMemoryReadAck, inputMemoryReadDataValid;
  logic [IW-1:0] inputMemoryReadAdd;
  logic [7:0] inputMemoryReadData;
  logic outputMemoryWriteReq, outputMemoryWriteAck, outputMemoryWriteByteMask;
  logic [OW-1:0] outputMemoryWriteAdd;
  logic [7:0] outputMemoryWriteData;
  logic pufTrigger, pufDone;
  logic [8*CB-1:0] pufChallenge;
  logic [15:0] pufOpA, pufOpB;
  logic [8*RB-1:0] pufResponse;
  logic [7:0] LED;

  puf_batch_controller #(
    .INMEM_ADDRESS_WIDTH(IW), .OUTMEM_ADDRESS_WIDTH(OW),
    .CHAL_BYTES(CB), .RESP_BYTES(RB), .TIMEOUT_CYCLES(20)
  ) dut (
    .clk(clk), .reset(reset), .userRunValue(userRunValue), .userRunClear(userRunClear),
    .register32CmdReq(register32CmdReq), .register32CmdAck(register32CmdAck),
    .register32WriteData(register32WriteData), .register32Address(register32Address),
    .register32WriteEn(register32WriteEn), .register32ReadDataValid(register32ReadDataValid),
    .register32ReadData(register32ReadData),
    .inputMemoryReadReq(inputMemoryReadReq), .inputMemoryReadAck(inputMemoryReadAck),
    .inputMemoryReadAdd(inputMemoryReadAdd), .inputMemoryReadDataValid(inputMemoryReadDataValid),
    .inputMemoryReadData(inputMemoryReadData),
    .outputMemoryWriteReq(outputMemoryWriteReq), .outputMemoryWriteAck(outputMemoryWriteAck),
    .outputMemoryWriteAdd(outputMemoryWriteAdd), .outputMemoryWriteData(outputMemoryWriteData),
    .outputMemoryWriteByteMask(outputMemoryWriteByteMask),
    .pufTrigger(pufTrigger), .pufChallenge(pufChallenge), .pufOpA(pufOpA), .pufOpB(pufOpB),
    .pufDone(pufDone), .pufResponse(pufResponse), .LED(LED)
  );

  initial forever #5 clk = ~clk;

  typedef struct {int addr; logic [7:0] data;} wr_t;

  int total = 0;
  int bad = 0;
  int expRd[$];
  int expParam[$];
  logic [31:0] expStatus[$];
  wr_t expWr[$];
  logic [127:0] expChal[$];
  logic [15:0] expOpA, expOpB;
  logic [31:0] regs[4];
  bit rndDelay = 0;
  int trigSeen = 0;
  int cfgMode[64];
  int cfgDelay[64];
  logic [15:0] cfgVal[64];
  int clearPulses = 0;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic int pickDelay();
    return rndDelay ? int'($urandom_range(0, 5)) : 0;
  endfunction

  // register file responder
  initial begin
    int d;
    logic [7:0] a;
    logic w;
    logic [31:0] wd;
    register32CmdAck = 0; register32ReadDataValid = 0; register32ReadData = 0;
    forever begin
      @(negedge clk);
      register32ReadDataValid = 0;
      if (register32CmdReq) begin
        d = pickDelay();
        repeat (d) @(negedge clk);
        if (register32CmdReq) begin
          a = register32Address; w = register32WriteEn; wd = register32WriteData;
          register32CmdAck = 1;
          @(negedge clk);
          register32CmdAck = 0;
          if (w) regs[a[1:0]] = wd;
          else begin
            register32ReadDataValid = 1;
            register32ReadData = regs[a[1:0]];
          end
        end
      end
    end
  end

  // input memory responder: byte at address a is a[7:0]
  initial begin
    int d;
    logic [IW-1:0] a;
    inputMemoryReadAck = 0; inputMemoryReadDataValid = 0; inputMemoryReadData = 0;
    forever begin
      @(negedge clk);
      inputMemoryReadDataValid = 0;
      if (inputMemoryReadReq) begin
        d = pickDelay();
        repeat (d) @(negedge clk);
        if (inputMemoryReadReq) begin
          a = inputMemoryReadAdd;
          inputMemoryReadAck = 1;
          @(negedge clk);
          inputMemoryReadAck = 0;
          inputMemoryReadDataValid = 1;
          inputMemoryReadData = a[7:0];
        end
      end
    end
  end

  // output memory responder
  initial begin
    int d;
    outputMemoryWriteAck = 0;
    forever begin
      @(negedge clk);
      if (outputMemoryWriteReq) begin
        d = pickDelay();
        repeat (d) @(negedge clk);
        if (outputMemoryWriteReq) begin
          outputMemoryWriteAck = 1;
          @(negedge clk);
          outputMemoryWriteAck = 0;
        end
      end
    end
  end

  // PUF model: mode 0 responds after cfgDelay cycles, 1 never, 2 strobes only in the trigger cycle
  initial begin
    int idx;
    pufDone = 0; pufResponse = 0;
    forever begin
      @(negedge clk);
      if (pufTrigger) begin
        idx = trigSeen;
        trigSeen++;
        if (expChal.size() == 0) check("chal_unexpected", 1, 0);
        else check("chal_value", pufChallenge, expChal.pop_front());
        check("op_a", pufOpA, expOpA);
        check("op_b", pufOpB, expOpB);
        check("busy_led", LED[0], 1);
        if (cfgMode[idx] == 2) begin
          pufDone = 1; pufResponse = 16'h1111;
          @(negedge clk);
          pufDone = 0;
          check("trig_pulse", pufTrigger, 0);
        end else begin
          @(negedge clk);
          check("trig_pulse", pufTrigger, 0);
          if (cfgMode[idx] == 0) begin
            repeat (cfgDelay[idx] - 1) @(negedge clk);
            pufDone = 1; pufResponse = cfgVal[idx];
            @(negedge clk);
            pufDone = 0;
          end
        end
      end
    end
  end

  // run register: cleared at the edge that ends the clear pulse
  initial forever begin
    @(negedge clk);
    if (userRunClear) begin
      clearPulses++;
      @(posedge clk);
      #1 userRunValue = 0;
      @(negedge clk);
      check("clear_width", userRunClear, 0);
    end
  end

  // handshake monitor
  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      #1;
      if (inputMemoryReadReq && inputMemoryReadAck) begin
        if (expRd.size() == 0) check("rd_unexpected", 1, 0);
        else check("rd_addr", inputMemoryReadAdd, expRd.pop_front());
      end
      if (outputMemoryWriteReq && outputMemoryWriteAck) begin
        if (expWr.size() == 0) check("wr_unexpected", 1, 0);
        else begin
          w = expWr.pop_front();
          check("wr_addr", outputMemoryWriteAdd, w.addr);
          check("wr_data", outputMemoryWriteData, w.data);
        end
      end
      if (register32CmdReq && register32CmdAck) begin
        if (register32WriteEn) begin
          check("status_addr", register32Address, 3);
          if (expStatus.size() == 0) check("status_unexpected", 1, 0);
          else check("status_word", register32WriteData, expStatus.pop_front());
        end else begin
          if (expParam.size() == 0) check("param_unexpected", 1, 0);
          else check("param_addr", register32Address, expParam.pop_front());
        end
      end
    end
  end

  task automatic pushParams();
    for (int i = 0; i < 3; i++) expParam.push_back(i);
    expOpA = regs[0][15:0];
    expOpB = regs[1][15:0];
  endtask

  task automatic pushChallenges(input int n);
    logic [127:0] c;
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < CB; i++) begin
        expRd.push_back(k*CB + i);
        c[8*i +: 8] = 8'(k*CB + i);
      end
      expChal.push_back(c);
    end
  endtask

  task automatic pushWrite(input int addr, input logic [7:0] data);
    wr_t w;
    w.addr = addr; w.data = data;
    expWr.push_back(w);
  endtask

  function automatic int pending();
    return expRd.size() + expWr.size() + expStatus.size() + expParam.size() + expChal.size();
  endfunction

  task automatic doRun(input string tag, input logic [7:0] expLed);
    int startClr;
    bit done;
    startClr = clearPulses;
    done = 0;
    userRunValue = 1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (clearPulses != startClr) begin done = 1; break; end
    end
    check({tag, "_finished"}, done, 1);
    repeat (6) @(negedge clk);
    check({tag, "_clear_count"}, clearPulses - startClr, 1);
    check({tag, "_led"}, LED, expLed);
    check({tag, "_all_consumed"}, pending(), 0);
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_outputs"}, {userRunClear, register32CmdReq, register32WriteData, register32Address,
          register32WriteEn, inputMemoryReadReq, inputMemoryReadAdd, outputMemoryWriteReq,
          outputMemoryWriteAdd, outputMemoryWriteData, pufTrigger, pufChallenge, pufOpA, pufOpB, LED}, '0);
    check({tag, "_bytemask"}, outputMemoryWriteByteMask, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int base;
    int startClr;
    bit reached;
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    reset = 0;
    @(negedge clk);

    // test 1: single challenge, response 0xBEEF after 10 cycles
    regs[0] = 32'h5A5A1234; regs[1] = 32'hC3C3ABCD; regs[2] = 32'd1; regs[3] = 0;
    base = trigSeen;
    cfgMode[base] = 0; cfgDelay[base] = 10; cfgVal[base] = 16'hBEEF;
    pushParams();
    for (int i = 0; i < CB; i++) expRd.push_back(i);
    expChal.push_back(128'h0F0E0D0C0B0A09080706050403020100);
    pushWrite(0, 8'hBE); pushWrite(1, 8'hEF);
    expStatus.push_back(32'h00000001);
    doRun("t1", 8'h02);
    check("t1_regfile_status", regs[3], 32'h00000001);

    // test 2: three challenges with random handshake delays; last PUF reply on the final allowed cycle
    rndDelay = 1;
    regs[2] = 32'h00070003;
    base = trigSeen;
    cfgMode[base]   = 0; cfgDelay[base]   = 1;  cfgVal[base]   = 16'h0102;
    cfgMode[base+1] = 0; cfgDelay[base+1] = 4;  cfgVal[base+1] = 16'h0304;
    cfgMode[base+2] = 0; cfgDelay[base+2] = 20; cfgVal[base+2] = 16'h0506;
    pushParams();
    pushChallenges(3);
    for (int j = 0; j < 6; j++) pushWrite(j, 8'(j + 1));
    expStatus.push_back(32'h00000003);
    doRun("t2", 8'h02);
    check("t2_triggers", trigSeen - base, 3);
    rndDelay = 0;

    // test 3: second challenge only strobes during the trigger cycle, then times out
    regs[2] = 32'd2;
    base = trigSeen;
    cfgMode[base] = 0; cfgDelay[base] = 3; cfgVal[base] = 16'h1357;
    cfgMode[base+1] = 2;
    pushParams();
    pushChallenges(2);
    pushWrite(0, 8'h13); pushWrite(1, 8'h57); pushWrite(2, 8'hFF); pushWrite(3, 8'hFF);
    expStatus.push_back(32'h00010002);
    doRun("t3", 8'h06);

    // test 4: empty batch
    regs[2] = 32'd0;
    pushParams();
    expStatus.push_back(32'h00000000);
    doRun("t4", 8'h02);

    // test 6: stray pufDone while idle, run register already released
    startClr = clearPulses;
    repeat (3) @(negedge clk);
    pufDone = 1; pufResponse = 16'h4242;
    @(negedge clk);
    pufDone = 0;
    repeat (30) @(negedge clk);
    check("t6_led", LED, 8'h02);
    check("t6_no_clear", clearPulses - startClr, 0);
    check("t6_no_requests", {register32CmdReq, inputMemoryReadReq, outputMemoryWriteReq, pufTrigger}, 0);

    // test 5: reset while evaluating challenge 2 of 4, then a clean single-challenge run
    regs[2] = 32'd4;
    base = trigSeen;
    cfgMode[base]   = 0; cfgDelay[base]   = 2;  cfgVal[base]   = 16'h2468;
    cfgMode[base+1] = 0; cfgDelay[base+1] = 15; cfgVal[base+1] = 16'h7777;
    pushParams();
    pushChallenges(2);
    pushWrite(0, 8'h24); pushWrite(1, 8'h68);
    userRunValue = 1;
    reached = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (trigSeen == base + 2) begin reached = 1; break; end
    end
    check("t5_reached_eval", reached, 1);
    repeat (5) @(negedge clk);
    reset = 1; userRunValue = 0;
    @(negedge clk);
    checkResetOutputs("t5_abort");
    reset = 0;
    check("t5_abort_consumed", pending(), 0);
    expRd.delete(); expWr.delete(); expChal.delete(); expParam.delete(); expStatus.delete();
    repeat (25) @(negedge clk);
    check("t5_idle_after_late_done", {LED, outputMemoryWriteReq}, 0);
    regs[2] = 32'd1;
    base = trigSeen;
    cfgMode[base] = 0; cfgDelay[base] = 4; cfgVal[base] = 16'h9ABC;
    pushParams();
    pushChallenges(1);
    pushWrite(0, 8'h9A); pushWrite(1, 8'hBC);
    expStatus.push_back(32'h00000001);
    doRun("t5b", 8'h02);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
